// File: rtl/uart_tx_arb.sv
// Line-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// Grant takes 1 cycle from IDLE; owner sees uart_tx_ready directly, losers see req_ready=0.
module uart_tx_arb #(
  parameter int                    NUM_REQ      = 2,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR     = 8'h0A,
  parameter int                    LOCK_TIMEOUT = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                 req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [DATA_WIDTH-1:0]                         uart_tx_data,
  output logic                                          uart_tx_valid,
  input  logic                                          uart_tx_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
  output logic                                          locked,
  output logic                                          timeout_evt
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [OW-1:0]         last_grant;
  logic [OW-1:0]         pick;
  logic [OW-1:0]         idx;
  logic [CW-1:0]         idle_cnt;
  logic [DATA_WIDTH-1:0] lane [NUM_REQ];
  logic [DATA_WIDTH-1:0] own_data;
  logic                  own_valid;
  logic                  xfer;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    own_valid = req_valid[owner];
    own_data  = lane[owner];
  end

  // Walk downward so the nearest requester after last_grant is the final (winning) assignment.
  always_comb begin
    pick = last_grant;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    uart_tx_valid = 1'b0;
    uart_tx_data  = '0;
    if (rst && state == LOCKED) begin
      req_ready[owner] = uart_tx_ready;
      uart_tx_valid    = own_valid;
      uart_tx_data     = own_data;
    end
  end

  assign xfer = uart_tx_valid && uart_tx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      locked      <= 1'b0;
      owner       <= '0;
      last_grant  <= OW'(NUM_REQ - 1);
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner    <= pick;
            locked   <= 1'b1;
            idle_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (own_data == EOL_CHAR) begin
              last_grant <= owner;
              locked     <= 1'b0;
              state      <= IDLE;
            end
          end else if (!own_valid) begin
            // Only an absent owner ages the lock; a stalled UART holds the count.
            if (idle_cnt >= CNT_LAST) begin
              last_grant  <= owner;
              locked      <= 1'b0;
              timeout_evt <= 1'b1;
              idle_cnt    <= '0;
              state       <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Line-granular arbiter that shares the single uart_tx transmitter between NUM_REQ byte sources, for example CPU console output and a debug monitor.
- Sits between the requesters and the uart_tx valid/ready interface, in the jpu_impl top level.
- Grants are round-robin. A grant is held until the owner sends EOL_CHAR, so text lines never interleave.
- An idle-owner timeout releases the lock if a requester stalls mid-line.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- DATA_WIDTH, 8: byte width; must equal UART_DATA_WIDTH.
- EOL_CHAR, 8'h0A: byte that ends a locked line and releases the grant.
- LOCK_TIMEOUT, 1024: owner-idle cycles before a forced release; legal range 1..65535.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset.
- req_valid, input, NUM_REQ: per-requester byte valid.
- req_data, input, NUM_REQ*DATA_WIDTH: packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, output, NUM_REQ: per-requester accept.
- uart_tx_data, output, DATA_WIDTH: byte to uart_tx.
- uart_tx_valid, output, 1: byte valid to uart_tx.
- uart_tx_ready, input, 1: uart_tx can accept a byte.
- owner, output, max(1,$clog2(NUM_REQ)): current grant index; meaningful only while locked=1.
- locked, output, 1: a requester currently holds the transmitter.
- timeout_evt, output, 1: one-cycle pulse on a forced release.

Behaviour:
- Reset: rst is synchronous and active-low; the clock is clk. While rst=0 at a posedge, the block loads:
  - state=IDLE, locked=0, owner=0, last_grant=NUM_REQ-1, idle_cnt=0, timeout_evt=0.
  - Outputs during reset: req_ready=0, uart_tx_valid=0, uart_tx_data=0.
- Transfer definition: a byte moves when uart_tx_valid && uart_tx_ready are both high at a posedge. The same condition is req_valid[owner] && req_ready[owner].
- Datapath outputs are combinational from registered state:
  - uart_tx_valid = (state==LOCKED) && req_valid[owner].
  - uart_tx_data = req_data[owner] when locked, else 0.
  - req_ready[i] = (state==LOCKED) && (i==owner) && uart_tx_ready.
  - All other req_ready bits are 0.
- IDLE state:
  - If any req_valid is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register owner to that index, set locked=1, go to LOCKED.
  - Arbitration latency is exactly 1 cycle: req_valid seen at edge t gives uart_tx_valid high after edge t, with no byte transferred during the IDLE cycle.
  - If no req_valid is set, remain in IDLE.
- LOCKED state:
  - On a transfer whose byte equals EOL_CHAR: last_grant<=owner, locked<=0, go to IDLE.
  - The EOL byte itself is sent under the current grant.
  - On a transfer with any other byte: idle_cnt<=0, stay in LOCKED.
  - When req_valid[owner]=0: idle_cnt increments. When idle_cnt reaches LOCK_TIMEOUT-1:
    - last_grant<=owner, locked<=0, timeout_evt<=1 for one cycle, go to IDLE.
  - While req_valid[owner]=1 and uart_tx_ready=0 (backpressure): idle_cnt holds. A stalled UART never causes a timeout.
- Fairness: after any release, the releasing requester has the lowest priority in the next arbitration.
- A requester without a grant may hold req_valid and req_data indefinitely; its data is not consumed.
- Owner requirement: the owner must keep req_data stable while req_valid=1 and req_ready=0. The arbiter does not buffer data.
- Simultaneous events: an EOL transfer on the same cycle that idle_cnt would expire is treated as an EOL release, with timeout_evt=0.
- Reset mid-line:
  - Any in-flight grant is dropped.
  - Outputs are zero on the cycle after the reset edge.
  - Arbitration restarts with requester 0 as the highest priority.
- idle_cnt width is $clog2(LOCK_TIMEOUT+1). It never wraps.

Test Plan:
- Single requester: req0 sends "Aq\n" (0x41, 0x71, 0x0A) with uart_tx_ready held high.
  - uart_tx_data sequence is 41, 71, 0A with owner=0.
  - locked falls the cycle after 0A; first valid appears 1 cycle after req_valid rises.
- Simultaneous requests: req0 sends "AB\n", req1 sends "pq\n", both raised in the same cycle after reset.
  - Output is exactly 41, 42, 0A, 70, 71, 0A, with no interleaving; req1 is stalled with req_ready[1]=0 throughout req0's line.
- Round-robin: both requesters continuously send single-byte lines of 0x0A.
  - Grants alternate 0, 1, 0, 1 across 8 lines.
- Timeout: LOCK_TIMEOUT=16; req0 sends 0x41, then drops valid, while req1 is pending.
  - timeout_evt pulses 16 cycles after the last transfer, then req1 is granted.
  - Repeat with uart_tx_ready=0 for 100 cycles and req0 still valid: no timeout occurs.
- Reset mid-line: assert rst=0 after req1 has sent 0x70 of "pq\n".
  - Next cycle: locked=0, uart_tx_valid=0, req_ready=0.
  - After release, with both requesters pending, req0 is granted first.
- Backpressure: toggle uart_tx_ready every 3 cycles while req0 sends 0x55, 0x0A.
  - Each byte transfers exactly once and only on cycles where ready is high; no byte is duplicated or dropped.
